// File: rtl/alu4_issuer_if.sv
// Request/response handshake bundle between the board-side logic and alu4_issuer.
interface alu4_issuer_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       req_cin;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [2:0] rsp_op;

    // Board side: issues requests and consumes responses.
    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_op
    );

    // Issuer side: accepts requests and offers responses.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_op
    );
endinterface

// File: rtl/alu4_issuer.sv
// Sequential initiator for the 4-bit combinational ALU: registers one request,
// holds the ALU inputs for SETTLE cycles, captures result/flags and offers them
// as a response.
module alu4_issuer #(
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu4_issuer_if.slave  bus,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [2:0]    alu_c,
    output logic          alu_cin,
    input  logic [3:0]    alu_result,
    input  logic          alu_zero,
    input  logic          alu_overflow,
    input  logic          alu_carry,
    input  logic          alu_size,
    output logic [7:0]    op_count,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic       req_fire;
    logic       rsp_fire;
    logic       settle_done;

    // Subtract-based ops need a carry-in of 1; logic ops ignore it and get 0.
    function automatic logic cin_for(input logic [2:0] op, input logic cin);
        logic res;
        case (op)
            3'b000:                 res = cin;
            3'b001, 3'b110, 3'b111: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    assign req_fire    = bus.req_valid && bus.req_ready;
    assign rsp_fire    = bus.rsp_valid && bus.rsp_ready;
    assign settle_done = (state == DRIVE) && (settle_cnt == SETTLE_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> hold operands for SETTLE cycles -> wait for consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire)    state_next = DRIVE;
            DRIVE:   if (settle_done) state_next = RESP;
            RESP:    if (rsp_fire)    state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only, so valid never depends on ready.
    always_comb begin
        bus.req_ready = (state == IDLE) && !rst;
        bus.rsp_valid = (state == RESP);
        busy          = (state != IDLE);
    end

    // ALU operand registers change only when a request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= 4'd0;
            alu_b   <= 4'd0;
            alu_c   <= 3'd0;
            alu_cin <= 1'b0;
        end else if (req_fire) begin
            alu_a   <= bus.req_a;
            alu_b   <= bus.req_b;
            alu_c   <= bus.req_op;
            alu_cin <= cin_for(bus.req_op, bus.req_cin);
        end
    end

    // Settle counter counts DRIVE cycles since the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 4'd0;
        end else if (req_fire) begin
            settle_cnt <= 4'd0;
        end else if (state == DRIVE) begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end

    // Response capture at the end of the last settle cycle; held until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_result <= 4'd0;
            bus.rsp_flags  <= 4'd0;
            bus.rsp_op     <= 3'd0;
        end else if (settle_done) begin
            bus.rsp_result <= alu_result;
            bus.rsp_flags  <= {alu_size, alu_carry, alu_overflow, alu_zero};
            bus.rsp_op     <= alu_c;
        end
    end

    // Completed-response counter, wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= 8'd0;
        end else if (rsp_fire) begin
            op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu4_issuer.sv
// Self-checking bench for alu4_issuer: a SETTLE=1 instance for the vector table,
// backpressure and counter wrap, and a SETTLE=3 instance for latency and reset.
module tb_alu4_issuer;

    logic clk;
    logic rst1;
    logic rst3;

    alu4_issuer_if bus1 ();
    alu4_issuer_if bus3 ();

    logic [3:0] alu_a1, alu_b1, alu_a3, alu_b3;
    logic [2:0] alu_c1, alu_c3;
    logic       alu_cin1, alu_cin3;
    logic [7:0] model1, model3;
    logic [7:0] op_count1, op_count3;
    logic       busy1, busy3;

    int total;
    int bad;
    int exp_count1;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       exp_cin;
        logic [3:0] exp_result;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[10];

    // Reference ALU: returns {size, carry, overflow, zero, result[3:0]}.
    function automatic logic [7:0] aluModel(input logic [2:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin);
        logic [3:0] bb;
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       v;
        bb = (op == 3'b000) ? b : ~b;
        s  = {1'b0, a} + {1'b0, bb} + {4'b0000, cin};
        c  = s[4];
        v  = (a[3] == bb[3]) && (s[3] != a[3]);
        case (op)
            3'b000, 3'b001: r = s[3:0];
            3'b010: r = ~a;
            3'b011: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: r = {3'b000, s[3] ^ v};
            default: r = {3'b000, (s[3:0] == 4'd0)};
        endcase
        if (op inside {3'b010, 3'b011, 3'b100, 3'b101}) begin
            c = 1'b0;
            v = 1'b0;
        end
        return {r[3], c, v, (r == 4'd0), r};
    endfunction

    assign model1 = aluModel(alu_c1, alu_a1, alu_b1, alu_cin1);
    assign model3 = aluModel(alu_c3, alu_a3, alu_b3, alu_cin3);

    alu4_issuer #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_c(alu_c1), .alu_cin(alu_cin1),
        .alu_result(model1[3:0]), .alu_zero(model1[4]), .alu_overflow(model1[5]),
        .alu_carry(model1[6]), .alu_size(model1[7]),
        .op_count(op_count1), .busy(busy1)
    );

    alu4_issuer #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3), .alu_cin(alu_cin3),
        .alu_result(model3[3:0]), .alu_zero(model3[4]), .alu_overflow(model3[5]),
        .alu_carry(model3[6]), .alu_size(model3[7]),
        .op_count(op_count3), .busy(busy3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full SETTLE=1 transaction on dut1 with checks at every phase.
    task automatic applyStimulus(input vec_t v);
        int n;
        @(negedge clk);
        bus1.req_op    = v.op;
        bus1.req_a     = v.a;
        bus1.req_b     = v.b;
        bus1.req_cin   = v.cin;
        bus1.req_valid = 1'b1;
        bus1.rsp_ready = 1'b0;
        n = 0;
        while (!bus1.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("req_ready_timeout", 0, 1);
        tick();
        bus1.req_valid = 1'b0;
        checkOutput("alu_a", alu_a1, v.a);
        checkOutput("alu_b", alu_b1, v.b);
        checkOutput("alu_c", alu_c1, v.op);
        checkOutput("alu_cin", alu_cin1, v.exp_cin);
        checkOutput("busy_drive", busy1, 1);
        checkOutput("req_ready_drive", bus1.req_ready, 0);
        checkOutput("rsp_valid_early", bus1.rsp_valid, 0);
        tick();
        checkOutput("rsp_valid", bus1.rsp_valid, 1);
        checkOutput("rsp_result", bus1.rsp_result, v.exp_result);
        checkOutput("rsp_flags", bus1.rsp_flags, v.exp_flags);
        checkOutput("rsp_op", bus1.rsp_op, v.op);
        bus1.rsp_ready = 1'b1;
        tick();
        bus1.rsp_ready = 1'b0;
        exp_count1 = (exp_count1 + 1) % 256;
        checkOutput("rsp_valid_clear", bus1.rsp_valid, 0);
        checkOutput("op_count", op_count1, exp_count1);
        checkOutput("req_ready_after", bus1.req_ready, 1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_count1 = 0;

        vecs[0] = '{3'b000, 4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 4'b1010};
        vecs[1] = '{3'b001, 4'b0011, 4'b0011, 1'b0, 1'b1, 4'b0000, 4'b0101};
        vecs[2] = '{3'b110, 4'b0010, 4'b1110, 1'b0, 1'b1, 4'b0000, 4'b0001};
        vecs[3] = '{3'b101, 4'b1010, 4'b0101, 1'b1, 1'b0, 4'b1111, 4'b1000};
        vecs[4] = '{3'b000, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0101};
        vecs[5] = '{3'b010, 4'b0101, 4'b0000, 1'b1, 1'b0, 4'b1010, 4'b1000};
        vecs[6] = '{3'b011, 4'b1100, 4'b1010, 1'b0, 1'b0, 4'b1000, 4'b1000};
        vecs[7] = '{3'b100, 4'b0001, 4'b0010, 1'b0, 1'b0, 4'b0011, 4'b0000};
        vecs[8] = '{3'b111, 4'b0110, 4'b0110, 1'b0, 1'b1, 4'b0001, 4'b0100};
        vecs[9] = '{3'b000, 4'b1000, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0111};

        bus1.req_valid = 1'b0; bus1.req_op = 3'd0; bus1.req_a = 4'd0;
        bus1.req_b = 4'd0; bus1.req_cin = 1'b0; bus1.rsp_ready = 1'b0;
        bus3.req_valid = 1'b0; bus3.req_op = 3'd0; bus3.req_a = 4'd0;
        bus3.req_b = 4'd0; bus3.req_cin = 1'b0; bus3.rsp_ready = 1'b0;
        rst1 = 1'b1;
        rst3 = 1'b1;

        // Reset state
        tick();
        tick();
        checkOutput("rst_req_ready", bus1.req_ready, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_rsp_valid", bus1.rsp_valid, 0);
        checkOutput("rst_alu_a", alu_a1, 0);
        checkOutput("rst_alu_cin", alu_cin1, 0);
        checkOutput("rst_op_count", op_count1, 0);
        checkOutput("rst_rsp_result", bus1.rsp_result, 0);
        checkOutput("rst_rsp_flags", bus1.rsp_flags, 0);
        checkOutput("rst_rsp_op", bus1.rsp_op, 0);
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
        #1;
        checkOutput("req_ready_post_rst", bus1.req_ready, 1);

        // Vector table on the SETTLE=1 instance
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Backpressure: response held, second request ignored
        @(negedge clk);
        bus1.req_op = 3'b000; bus1.req_a = 4'b0011; bus1.req_b = 4'b0100;
        bus1.req_cin = 1'b1; bus1.req_valid = 1'b1; bus1.rsp_ready = 1'b0;
        tick();
        bus1.req_valid = 1'b0;
        tick();
        checkOutput("bp_rsp_valid_rise", bus1.rsp_valid, 1);
        bus1.req_op = 3'b011; bus1.req_a = 4'b1111; bus1.req_b = 4'b1111;
        bus1.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("bp_rsp_valid", bus1.rsp_valid, 1);
            checkOutput("bp_rsp_result", bus1.rsp_result, 4'b1000);
            checkOutput("bp_rsp_flags", bus1.rsp_flags, 4'b1010);
            checkOutput("bp_rsp_op", bus1.rsp_op, 3'b000);
            checkOutput("bp_req_ready", bus1.req_ready, 0);
            checkOutput("bp_alu_a", alu_a1, 4'b0011);
        end
        bus1.req_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        tick();
        bus1.rsp_ready = 1'b0;
        exp_count1 = (exp_count1 + 1) % 256;
        checkOutput("bp_op_count", op_count1, exp_count1);
        checkOutput("bp_rsp_valid_clear", bus1.rsp_valid, 0);
        checkOutput("bp_req_ready_after", bus1.req_ready, 1);
        checkOutput("bp_alu_c_kept", alu_c1, 3'b000);

        // SETTLE=3 latency and operand stability
        @(negedge clk);
        bus3.req_op = 3'b011; bus3.req_a = 4'b1100; bus3.req_b = 4'b1010;
        bus3.req_cin = 1'b1; bus3.req_valid = 1'b1;
        tick();
        bus3.req_valid = 1'b0;
        checkOutput("s3_alu_a", alu_a3, 4'b1100);
        checkOutput("s3_alu_cin", alu_cin3, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput("s3_rsp_valid", bus3.rsp_valid, (k >= 3) ? 1 : 0);
            checkOutput("s3_alu_a_hold", alu_a3, 4'b1100);
            checkOutput("s3_alu_b_hold", alu_b3, 4'b1010);
            checkOutput("s3_alu_c_hold", alu_c3, 3'b011);
        end
        checkOutput("s3_rsp_result", bus3.rsp_result, 4'b1000);
        checkOutput("s3_rsp_flags", bus3.rsp_flags, 4'b1000);
        bus3.rsp_ready = 1'b1;
        tick();
        bus3.rsp_ready = 1'b0;
        checkOutput("s3_op_count", op_count3, 1);

        // Reset during the second DRIVE cycle discards the transaction
        @(negedge clk);
        bus3.req_op = 3'b000; bus3.req_a = 4'b0001; bus3.req_b = 4'b0001;
        bus3.req_cin = 1'b0; bus3.req_valid = 1'b1; bus3.rsp_ready = 1'b1;
        tick();
        bus3.req_valid = 1'b0;
        tick();
        checkOutput("mr_busy_before", busy3, 1);
        rst3 = 1'b1;
        tick();
        checkOutput("mr_rsp_valid", bus3.rsp_valid, 0);
        checkOutput("mr_alu_a", alu_a3, 0);
        checkOutput("mr_alu_b", alu_b3, 0);
        checkOutput("mr_alu_c", alu_c3, 0);
        checkOutput("mr_alu_cin", alu_cin3, 0);
        checkOutput("mr_op_count", op_count3, 0);
        checkOutput("mr_busy", busy3, 0);
        checkOutput("mr_req_ready_in_rst", bus3.req_ready, 0);
        rst3 = 1'b0;
        tick();
        checkOutput("mr_req_ready", bus3.req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("mr_no_rsp", bus3.rsp_valid, 0);
        end

        // Counter wrap over 256 back-to-back ops
        @(negedge clk);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        checkOutput("wrap_start", op_count1, 0);
        bus1.req_op = 3'b101; bus1.req_a = 4'b1010; bus1.req_b = 4'b0101;
        bus1.req_cin = 1'b0; bus1.rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int n;
            bus1.req_valid = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
            end while (!busy1 && n < 20);
            bus1.req_valid = 1'b0;
            while (!bus1.rsp_valid && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) begin
                checkOutput("wrap_timeout", 0, 1);
                break;
            end
            tick();
            if (i == 254) checkOutput("wrap_255", op_count1, 255);
            if (i == 255) checkOutput("wrap_0", op_count1, 0);
        end
        bus1.rsp_ready = 1'b0;
        checkOutput("wrap_result", bus1.rsp_result, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
